// File: rtl/icache_pkg.sv
// Shared types and default geometry for the instruction-cache tag path.
// Default widths follow a 2048-set cache with 16-byte lines and 32-bit fetch addresses.
package icache_pkg;

  localparam int ICACHE_NO_OF_SETS   = 2048;
  localparam int ICACHE_ADDR_W       = 32;
  localparam int ICACHE_OFFSET_BITS  = 4;
  localparam int ICACHE_INDEX_BITS   = $clog2(ICACHE_NO_OF_SETS);
  localparam int ICACHE_TAG_BITS     = ICACHE_ADDR_W - ICACHE_INDEX_BITS - ICACHE_OFFSET_BITS;

  typedef enum logic [2:0] {
    ST_FLUSH   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_COMPARE = 3'd2,
    ST_REFILL  = 3'd3,
    ST_UPDATE  = 3'd4
  } icache_tag_state_e;

  typedef struct packed {
    logic                       valid;
    logic [ICACHE_TAG_BITS-1:0] tag;
  } icache_tag_entry_t;

endpackage

// File: rtl/icache_tag_ctrl.sv
// Tag lookup / refill controller driving the single-port icache tag RAM.
// Sweeps every set invalid after reset and on flush; handshakes: lkup_req_i is taken when lkup_ready_o is high, mem_req_o holds until mem_ack_i.
module icache_tag_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W      = ICACHE_ADDR_W,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lkup_req_i,
  input  logic [ADDR_W-1:0]     lkup_addr_i,
  output logic                  lkup_ready_o,
  output logic                  rsp_valid_o,
  output logic                  rsp_hit_o,
  input  logic                  flush_i,
  output logic                  flush_busy_o,
  output logic                  mem_req_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic                  mem_ack_i,
  output logic                  tag_req_o,
  output logic                  tag_wr_o,
  output logic [INDEX_BITS-1:0] tag_addr_o,
  output logic [TAG_BITS:0]     tag_wdata_o,
  input  logic [TAG_BITS:0]     tag_rdata_i,
  output icache_tag_state_e     dbg_state_o
);

  localparam int LINE_W = ADDR_W - OFFSET_BITS;

  icache_tag_state_e     r_state;
  icache_tag_state_e     w_state_nxt;
  logic [INDEX_BITS-1:0] r_cnt;
  logic                  r_flush_pending;
  logic                  r_mem_req;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [LINE_W-1:0]     r_line;

  logic [TAG_BITS-1:0]   w_tag_q;
  logic [INDEX_BITS-1:0] w_idx_q;
  logic [INDEX_BITS-1:0] w_idx_in;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_tag_req;
  logic                  w_unused_offset;

  // Only the line address is kept; byte offset within the line plays no part in tagging.
  assign w_unused_offset = ^lkup_addr_i[OFFSET_BITS-1:0];

  assign w_tag_q  = r_line[LINE_W-1:INDEX_BITS];
  assign w_idx_q  = r_line[INDEX_BITS-1:0];
  assign w_idx_in = lkup_addr_i[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign w_hit    = tag_rdata_i[TAG_BITS] && (tag_rdata_i[TAG_BITS-1:0] == w_tag_q);

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_tag_req    = 1'b0;
    lkup_ready_o = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_hit_o    = 1'b0;
    flush_busy_o = 1'b0;
    tag_wr_o     = 1'b0;
    tag_addr_o   = '0;
    tag_wdata_o  = '0;
    case (r_state)
      ST_FLUSH: begin
        flush_busy_o = 1'b1;
        w_tag_req    = 1'b1;
        tag_wr_o     = 1'b1;
        tag_addr_o   = r_cnt;
        if (r_cnt == {INDEX_BITS{1'b1}}) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        lkup_ready_o = !r_flush_pending && !flush_i;
        if (flush_i || r_flush_pending) begin
          w_state_nxt = ST_FLUSH;
        end else if (lkup_req_i) begin
          w_accept    = 1'b1;
          w_tag_req   = 1'b1;
          tag_addr_o  = w_idx_in;
          w_state_nxt = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (w_hit) begin
          rsp_valid_o = 1'b1;
          rsp_hit_o   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_ack_i) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_tag_req   = 1'b1;
        tag_wr_o    = 1'b1;
        tag_addr_o  = w_idx_q;
        tag_wdata_o = {1'b1, w_tag_q};
        rsp_valid_o = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_FLUSH;
      r_cnt           <= '0;
      r_flush_pending <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_line          <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FLUSH) r_cnt <= r_cnt + 1'b1;
      // A flush seen mid-lookup waits in pending; IDLE always consumes it on the way to FLUSH.
      if (r_state == ST_IDLE) r_flush_pending <= 1'b0;
      else if (flush_i && r_state != ST_FLUSH) r_flush_pending <= 1'b1;
      if (w_accept) r_line <= lkup_addr_i[ADDR_W-1:OFFSET_BITS];
      if (r_state == ST_COMPARE && !w_hit) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= {r_line, {OFFSET_BITS{1'b0}}};
      end else if (r_state == ST_REFILL && mem_ack_i) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  // Gate with reset so the RAM port is quiet while rst_n is low.
  assign tag_req_o   = w_tag_req && rst_n;
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_mem_addr;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Self-checking bench for icache_tag_ctrl with a behavioural tag RAM and a reference tag model.
// Responses are predicted at lookup acceptance and checked when rsp_valid_o fires.
module tb_icache_tag_ctrl;
  import icache_pkg::*;

  localparam int SETS = 2048;

  logic        clk;
  logic        rst_n;
  logic        lkup_req;
  logic [31:0] lkup_addr;
  logic        lkup_ready_o;
  logic        rsp_valid_o;
  logic        rsp_hit_o;
  logic        flush_i;
  logic        flush_busy_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack;
  logic        tag_req_o;
  logic        tag_wr_o;
  logic [10:0] tag_addr_o;
  logic [17:0] tag_wdata_o;
  logic [17:0] tag_rdata;
  icache_tag_state_e dbg_state_o;

  icache_tag_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lkup_req_i   (lkup_req),
    .lkup_addr_i  (lkup_addr),
    .lkup_ready_o (lkup_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_hit_o    (rsp_hit_o),
    .flush_i      (flush_i),
    .flush_busy_o (flush_busy_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack),
    .tag_req_o    (tag_req_o),
    .tag_wr_o     (tag_wr_o),
    .tag_addr_o   (tag_addr_o),
    .tag_wdata_o  (tag_wdata_o),
    .tag_rdata_i  (tag_rdata),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural tag RAM ----------------
  logic [17:0] tag_mem [SETS];
  always @(posedge clk) begin
    if (tag_req_o) begin
      if (tag_wr_o) tag_mem[tag_addr_o] <= tag_wdata;
      else          tag_rdata <= tag_mem[tag_addr_o];
    end
  end
  logic [17:0] tag_wdata;
  assign tag_wdata = tag_wdata_o;

  // ---------------- reference model + scoreboard ----------------
  bit          m_valid [SETS];
  logic [16:0] m_tag   [SETS];
  logic [0:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h @%0t", name, got, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && rsp_valid_o) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
      else check("rsp_hit", {63'd0, rsp_hit_o}, {63'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks (entered and left at negedge+1) ----------------
  task automatic check_sweep();
    int err = 0;
    for (int i = 0; i < SETS; i++) begin
      if (!(flush_busy_o && tag_req_o && tag_wr_o && tag_addr_o == 11'(i) &&
            tag_wdata_o == 18'd0 && !lkup_ready_o)) err++;
      @(negedge clk); #1;
    end
    check("sweep_errors", 64'(err), 64'd0);
    check("sweep_done_busy", {63'd0, flush_busy_o}, 64'd0);
    check("sweep_done_ready", {63'd0, lkup_ready_o}, 64'd1);
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!lkup_ready_o && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    check("ready_timeout", 64'(t >= 3000), 64'd0);
  endtask

  // mode 0: normal, 1: flush pulse during REFILL, 2: reset during REFILL
  task automatic do_lookup(input logic [31:0] addr, input int ack_dly, input int mode);
    logic [10:0] idx;
    logic [16:0] tg;
    logic        hit;
    int          err;
    idx = addr[14:4];
    tg  = addr[31:15];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    wait_ready();
    lkup_req  = 1'b1;
    lkup_addr = addr;
    #1;
    check("acc_tag_req", {63'd0, tag_req_o}, 64'd1);
    check("acc_tag_wr", {63'd0, tag_wr_o}, 64'd0);
    check("acc_tag_addr", 64'(tag_addr_o), 64'(idx));
    exp_q.push_back(hit);
    @(negedge clk);
    lkup_req = 1'b0;
    #1;
    check("cmp_rsp_valid", {63'd0, rsp_valid_o}, {63'd0, hit});
    check("cmp_mem_req", {63'd0, mem_req_o}, 64'd0);
    check("cmp_tag_req", {63'd0, tag_req_o}, 64'd0);
    @(negedge clk); #1;
    if (hit) begin
      check("hit_no_mem_req", {63'd0, mem_req_o}, 64'd0);
      return;
    end
    check("refill_state", 64'(dbg_state_o), 64'(ST_REFILL));
    check("refill_req", {63'd0, mem_req_o}, 64'd1);
    check("refill_addr", 64'(mem_addr_o), 64'({addr[31:4], 4'h0}));
    if (mode == 2) begin
      rst_n = 1'b0;
      #1;
      check("reset_drops_mem_req", {63'd0, mem_req_o}, 64'd0);
      check("reset_tag_req", {63'd0, tag_req_o}, 64'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      return;
    end
    err = 0;
    for (int k = 0; k < ack_dly; k++) begin
      if (mode == 1 && k == 1) flush_i = 1'b1;
      if (mode == 1 && k == 2) flush_i = 1'b0;
      @(negedge clk); #1;
      if (!mem_req_o || mem_addr_o != {addr[31:4], 4'h0} || tag_req_o || rsp_valid_o) err++;
    end
    check("refill_hold_errors", 64'(err), 64'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("upd_mem_req", {63'd0, mem_req_o}, 64'd0);
    check("upd_tag_wr", {63'd0, tag_req_o & tag_wr_o}, 64'd1);
    check("upd_tag_addr", 64'(tag_addr_o), 64'(idx));
    check("upd_tag_wdata", 64'(tag_wdata_o), 64'({1'b1, tg}));
    check("upd_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    @(negedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra;
    rst_n     = 1'b0;
    lkup_req  = 1'b1;
    lkup_addr = 32'h0;
    flush_i   = 1'b0;
    mem_ack   = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      tag_mem[i] = 18'($urandom);
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    check("rst_flush_busy", {63'd0, flush_busy_o}, 64'd1);
    check("rst_ready", {63'd0, lkup_ready_o}, 64'd0);
    check("rst_tag_req", {63'd0, tag_req_o}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'(ST_FLUSH));

    // Test 1: init sweep with lookup held high
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_sweep();
    check("init_accept_tag_req", {63'd0, tag_req_o}, 64'd1);
    lkup_req = 1'b0;
    #1;

    // Tests 2-4: miss/refill, hit, tag replacement
    do_lookup(32'h8000_1234, 5, 0);
    do_lookup(32'h8000_1238, 0, 0);
    do_lookup(32'h0000_1234, 3, 0);
    do_lookup(32'h8000_1234, 3, 0);

    // Random lines: first touch then a second access to the same line
    for (int n = 0; n < 6; n++) begin
      ra = $urandom;
      do_lookup(ra, $urandom_range(3, 8), 0);
      do_lookup({ra[31:4], 4'($urandom_range(0, 15))}, 3, 0);
    end

    // Test 5: flush during REFILL
    do_lookup(32'h0000_5670, 4, 1);
    check("pending_blocks_ready", {63'd0, lkup_ready_o}, 64'd0);
    @(negedge clk); #1;
    check("pending_enters_flush", 64'(dbg_state_o), 64'(ST_FLUSH));
    check_sweep();
    do_lookup(32'h0000_1234, 3, 0);

    // Test 6a: flush and lookup in the same IDLE cycle
    wait_ready();
    flush_i   = 1'b1;
    lkup_req  = 1'b1;
    lkup_addr = 32'h0000_1234;
    #1;
    check("flush_prio_ready", {63'd0, lkup_ready_o}, 64'd0);
    check("flush_prio_tag_req", {63'd0, tag_req_o}, 64'd0);
    @(negedge clk);
    flush_i  = 1'b0;
    lkup_req = 1'b0;
    #1;
    check("flush_prio_state", 64'(dbg_state_o), 64'(ST_FLUSH));
    check_sweep();

    // Test 6b: reset mid-refill, sweep restarts at set 0
    do_lookup(32'h1234_5670, 4, 0);
    do_lookup(32'h4321_0670, 4, 2);
    check_sweep();
    do_lookup(32'h1234_5670, 3, 0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
